// File: rtl/rise_stable_pkg.sv
// Shared types and default widths for the rise/stable pulse-train generator.
package rise_stable_pkg;

  localparam int unsigned DefaultCw = 8;
  localparam int unsigned DefaultNw = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StFin
  } state_t;

endpackage

// File: rtl/span_down_counter.sv
// Loadable down-counter timing one low or high span; flags when the span's last cycle is reached.
module span_down_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] value_i,
  input  logic          en_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;

  // Load wins over decrement; the count holds at zero rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rise_stable_gen.sv
// Burst generator: drives sig_out as N low/high pulses with exact span lengths,
// sequenced by a start/busy/done handshake.
module rise_stable_gen
  import rise_stable_pkg::*;
#(
  parameter int unsigned CW = DefaultCw,
  parameter int unsigned NW = DefaultNw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] low_cycles,
  input  logic [CW-1:0] high_cycles,
  input  logic [NW-1:0] num_pulses,
  output logic          sig_out,
  output logic          rose_strb,
  output logic          busy,
  output logic          done
);

  // A zero span length behaves as one cycle; counters run from span-1 down to 0.
  function automatic logic [CW-1:0] span_m1(input logic [CW-1:0] span);
    return (span == '0) ? '0 : span - CW'(1);
  endfunction

  state_t        state_q;
  logic [CW-1:0] low_m1_q;
  logic [CW-1:0] high_m1_q;
  logic [NW-1:0] pulse_q;
  logic          sig_out_q;
  logic          rose_strb_q;
  logic          busy_q;
  logic          done_q;

  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_en;
  logic          cnt_zero;

  span_down_counter #(
    .CW(CW)
  ) u_span_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (cnt_load),
    .value_i(cnt_val),
    .en_i   (cnt_en),
    .zero_o (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = low_m1_q;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = span_m1(low_cycles);
        end
      end
      StLow: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = high_m1_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StHigh: begin
        if (cnt_zero) begin
          if (pulse_q != NW'(1)) begin
            cnt_load = 1'b1;
            cnt_val  = low_m1_q;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      StFin: begin
        cnt_load = 1'b0;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      low_m1_q    <= '0;
      high_m1_q   <= '0;
      pulse_q     <= '0;
      sig_out_q   <= 1'b0;
      rose_strb_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sig_out_q   <= (state_q == StHigh);
      rose_strb_q <= (state_q == StHigh) && !sig_out_q;
      busy_q      <= (state_q == StLow) || (state_q == StHigh);
      done_q      <= (state_q == StFin);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            low_m1_q  <= span_m1(low_cycles);
            high_m1_q <= span_m1(high_cycles);
            pulse_q   <= num_pulses;
            state_q   <= (num_pulses == '0) ? StFin : StLow;
          end
        end
        StLow: begin
          if (cnt_zero) begin
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (cnt_zero) begin
            if (pulse_q == NW'(1)) begin
              state_q <= StFin;
            end else begin
              pulse_q <= pulse_q - NW'(1);
              state_q <= StLow;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign sig_out   = sig_out_q;
  assign rose_strb = rose_strb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rise_stable_gen.sv
// Directed bench for rise_stable_gen: per-cycle output patterns plus span-length and protocol checks.
module tb_rise_stable_gen;

  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] low_cycles;
  logic [CW-1:0] high_cycles;
  logic [NW-1:0] num_pulses;
  logic          sig_out;
  logic          rose_strb;
  logic          busy;
  logic          done;

  int total;
  int bad;

  // Effective span lengths of the burst in flight, and run-length tracking of sig_out.
  int   exp_l;
  int   exp_h;
  logic prev_sig;
  int   run_len;
  logic run_busy;

  rise_stable_gen #(
    .CW(CW),
    .NW(NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .low_cycles (low_cycles),
    .high_cycles(high_cycles),
    .num_pulses (num_pulses),
    .sig_out    (sig_out),
    .rose_strb  (rose_strb),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_rose_edge: assert property (@(posedge clk) disable iff (rst) rose_strb |-> $rose(sig_out))
    else begin
      bad++;
      $error("FAIL rose_edge observed rose_strb=1 sig_out=%b expected a rise of sig_out", sig_out);
    end

  a_edge_rose: assert property (@(posedge clk) disable iff (rst) $rose(sig_out) |-> rose_strb)
    else begin
      bad++;
      $error("FAIL edge_rose observed rose_strb=%b on sig_out rise expected 1", rose_strb);
    end

  a_busy_done: assert property (@(posedge clk) disable iff (rst) !(busy && done))
    else begin
      bad++;
      $error("FAIL busy_done observed busy=%b done=%b expected not both 1", busy, done);
    end

  a_done_low: assert property (@(posedge clk) disable iff (rst) done |-> !sig_out)
    else begin
      bad++;
      $error("FAIL done_low observed sig_out=%b with done=1 expected 0", sig_out);
    end

  // {busy, sig_out, rose_strb, done} per pattern letter.
  function automatic logic [3:0] code(input byte c);
    case (c)
      "L":     return 4'b1000;
      "R":     return 4'b1110;
      "H":     return 4'b1100;
      "F":     return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed={busy,sig,rose,done}=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      prev_sig = sig_out;
      run_len  = 1;
      run_busy = busy;
    end else if (sig_out !== prev_sig) begin
      if (run_busy) begin
        if (prev_sig) chk_int("high_span_len", run_len, exp_h);
        else          chk_int("low_span_len", run_len, exp_l);
      end
      prev_sig = sig_out;
      run_len  = 1;
      run_busy = busy;
    end else begin
      run_len++;
      run_busy = run_busy & busy;
    end
  endtask

  task automatic expect_run(input string tag, input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      tick();
      chk_vec($sformatf("%s[%0d]", tag, i + 1), {busy, sig_out, rose_strb, done}, code(pat[i]));
    end
  endtask

  // Presents cfg with start=1 across one edge (edge 0 of the burst).
  task automatic launch(input int l, input int h, input int n, input bit hold);
    low_cycles  = CW'(l);
    high_cycles = CW'(h);
    num_pulses  = NW'(n);
    exp_l       = (l == 0) ? 1 : l;
    exp_h       = (h == 0) ? 1 : h;
    start       = 1'b1;
    tick();
    if (!hold) start = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    exp_l       = 1;
    exp_h       = 1;
    prev_sig    = 1'b0;
    run_len     = 0;
    run_busy    = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    low_cycles  = '0;
    high_cycles = '0;
    num_pulses  = '0;

    expect_run("reset", "III");
    rst = 1'b0;
    expect_run("idle", "II");

    // 1: L=2 H=3 N=1, rise after edge 3, done after edge 6.
    launch(2, 3, 1, 1'b0);
    expect_run("t1", "LLRHHFII");

    // 2: zero spans behave as one cycle.
    launch(0, 0, 3, 1'b0);
    expect_run("t2", "LRLRLRFI");

    // 3: empty burst.
    launch(5, 5, 0, 1'b0);
    expect_run("t3", "FII");

    // 4: start re-pulsed and cfg changed mid-burst must not disturb it.
    launch(2, 1, 2, 1'b0);
    low_cycles  = 8'd7;
    high_cycles = 8'd9;
    num_pulses  = 4'd5;
    expect_run("t4a", "LL");
    start = 1'b1;
    expect_run("t4b", "RL");
    start       = 1'b0;
    low_cycles  = 8'd1;
    high_cycles = 8'd0;
    expect_run("t4c", "LRFI");

    // 5: reset while the second pulse is high, then a normal burst.
    launch(1, 3, 2, 1'b0);
    expect_run("t5a", "LRHHLR");
    rst = 1'b1;
    expect_run("t5rst", "I");
    rst = 1'b0;
    expect_run("t5idle", "II");
    launch(2, 3, 1, 1'b0);
    expect_run("t5b", "LLRHHFI");

    // 6: start held high gives back-to-back bursts with FIN and IDLE between.
    launch(1, 1, 2, 1'b1);
    expect_run("t6a", "LRLRFILRLRF");
    start = 1'b0;
    expect_run("t6b", "II");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
